// File: rtl/line_mem_pkg.sv
// Shared types and width helpers for the line memory controller.
// Holds the controller state enum plus constant functions that turn the
// cache geometry parameters into derived widths (words per line, line
// width, line address width) and a minimum-1 clog2 used for counters.
package line_mem_pkg;

  typedef enum logic [1:0] {IDLE, DELAY, XFER, ACK} lm_state_e;

  function automatic int words_f(input int lwa);
    return 1 << lwa;
  endfunction

  function automatic int line_w_f(input int lwa);
    return 32 * (1 << lwa);
  endfunction

  function automatic int mem_addr_len_f(input int tag_len, input int idx_len);
    return tag_len + idx_len;
  endfunction

  // Bits needed to index n distinct values, never less than 1.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_f(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/line_mem_ctrl_if.sv
// Bus bundle between the requesters/RAM side and line_mem_ctrl.
//   req_valid/req_we/req_addr/req_wline : per-channel line requests (flat)
//   ack/rd_line/busy                    : completion pulse, last read line, status
//   ram_addr/ram_din/ram_we/ram_dout    : single-port word RAM port
// master = requesters + RAM model, slave = controller.
interface line_mem_ctrl_if
  import line_mem_pkg::*;
#(
  parameter int NCH               = 2,
  parameter int TAG_LEN           = 2,
  parameter int INDEX_ADDR_LEN    = 6,
  parameter int LINEWORD_ADDR_LEN = 2
);
  localparam int MAW    = mem_addr_len_f(TAG_LEN, INDEX_ADDR_LEN);
  localparam int LINE_W = line_w_f(LINEWORD_ADDR_LEN);
  localparam int RAW    = MAW + LINEWORD_ADDR_LEN;

  logic [NCH-1:0]        req_valid;
  logic [NCH-1:0]        req_we;
  logic [NCH*MAW-1:0]    req_addr;
  logic [NCH*LINE_W-1:0] req_wline;
  logic [NCH-1:0]        ack;
  logic [LINE_W-1:0]     rd_line;
  logic                  busy;
  logic [RAW-1:0]        ram_addr;
  logic [31:0]           ram_din;
  logic                  ram_we;
  logic [31:0]           ram_dout;

  modport master (
    output req_valid, req_we, req_addr, req_wline, ram_dout,
    input  ack, rd_line, busy, ram_addr, ram_din, ram_we
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wline, ram_dout,
    output ack, rd_line, busy, ram_addr, ram_din, ram_we
  );

endinterface

// File: rtl/line_mem_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i     : request vector
//   ptr_i     : highest-priority channel this round
//   gnt_oh_o  : one-hot grant (first set request at or after ptr_i, cyclic)
//   gnt_idx_o : index of the granted channel
//   gnt_vld_o : any request present
module rr_arbiter #(
  parameter int NCH = 2,
  parameter int PW  = 1
) (
  input  logic [NCH-1:0] req_i,
  input  logic [PW-1:0]  ptr_i,
  output logic [NCH-1:0] gnt_oh_o,
  output logic [PW-1:0]  gnt_idx_o,
  output logic           gnt_vld_o
);

  logic [PW-1:0] c;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    c         = '0;
    for (int i = 0; i < NCH; i++) begin
      c = PW'((int'(ptr_i) + i) % NCH);
      if (!gnt_vld_o && req_i[c]) begin
        gnt_vld_o   = 1'b1;
        gnt_oh_o[c] = 1'b1;
        gnt_idx_o   = c;
      end
    end
  end

endmodule

// File: rtl/line_mem_ctrl.sv
// Block-granular main-memory controller.
// Serves whole-line reads/writes from NCH requesters (round-robin), models a
// programmable access latency, then bursts one word per cycle to an external
// synchronous single-port word RAM with RAM_RD_LAT read latency.
//   clk, rstn : clock, async active-low reset
//   bus       : line_mem_ctrl_if slave (request side + RAM side)
module line_mem_ctrl
  import line_mem_pkg::*;
#(
  parameter int NCH               = 2,
  parameter int TAG_LEN           = 2,
  parameter int INDEX_ADDR_LEN    = 6,
  parameter int LINEWORD_ADDR_LEN = 2,
  parameter int RD_LAT            = 16,
  parameter int WR_LAT            = 16,
  parameter int RAM_RD_LAT        = 1
) (
  input  logic            clk,
  input  logic            rstn,
  line_mem_ctrl_if.slave  bus
);

  localparam int LWA    = LINEWORD_ADDR_LEN;
  localparam int WORDS  = words_f(LWA);
  localparam int LINE_W = line_w_f(LWA);
  localparam int MAW    = mem_addr_len_f(TAG_LEN, INDEX_ADDR_LEN);
  localparam int PW     = clog2w(NCH);
  localparam int DW     = clog2w(max_f(RD_LAT, WR_LAT) + 1);
  localparam int XW     = LWA + clog2w(RAM_RD_LAT + 1);

  localparam logic [DW-1:0] RD_LAT_C = DW'(RD_LAT);
  localparam logic [DW-1:0] WR_LAT_C = DW'(WR_LAT);
  localparam logic [XW-1:0] WORDS_C  = XW'(WORDS);
  localparam logic [XW-1:0] RRL_C    = XW'(RAM_RD_LAT);
  localparam logic [XW-1:0] WR_LAST  = XW'(WORDS - 1);
  localparam logic [XW-1:0] RD_LAST  = XW'(WORDS - 1 + RAM_RD_LAT);

  typedef struct packed {
    logic                   we;
    logic [MAW-1:0]         addr;
    logic [WORDS-1:0][31:0] wline;
  } req_t;

  lm_state_e              state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [NCH-1:0]         gnt_q;
  req_t                   req_q;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic [XW-1:0]          xcnt_q, xcnt_d;
  logic [WORDS-1:0][31:0] buf_q, buf_d;
  logic [WORDS-1:0][31:0] rd_line_q;

  req_t                   ch_req [NCH];
  logic [NCH-1:0]         gnt_oh;
  logic [PW-1:0]          gnt_idx;
  logic                   gnt_vld;
  logic                   grant;
  logic [DW-1:0]          lat_sel;
  logic [XW-1:0]          xfer_last;
  logic                   issue;
  logic                   cap_en, cap_last;
  logic [LWA-1:0]         cap_slot;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign ch_req[g].we    = bus.req_we[g];
    assign ch_req[g].addr  = bus.req_addr[g*MAW +: MAW];
    assign ch_req[g].wline = bus.req_wline[g*LINE_W +: LINE_W];
  end

  rr_arbiter #(.NCH(NCH), .PW(PW)) u_arb (
    .req_i     (bus.req_valid),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  // Pointer moves just past the winner; with NCH=1 this is constant 0.
  assign ptr_d     = (gnt_idx == PW'(NCH - 1)) ? '0 : gnt_idx + PW'(1);
  assign lat_sel   = ch_req[gnt_idx].we ? WR_LAT_C : RD_LAT_C;
  // Reads stay in XFER RAM_RD_LAT extra cycles to drain the RAM pipeline.
  assign xfer_last = req_q.we ? WR_LAST : RD_LAST;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    xcnt_d  = xcnt_q;
    grant   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          grant  = 1'b1;
          xcnt_d = '0;
          if (lat_sel == '0) begin
            state_d = XFER;
          end else begin
            state_d = DELAY;
            dcnt_d  = lat_sel;
          end
        end
      end
      DELAY: begin
        // Loaded with LAT, leaves when it hits 0: exactly LAT cycles here.
        dcnt_d = dcnt_q - 1'b1;
        if (dcnt_q == DW'(1)) state_d = XFER;
      end
      XFER: begin
        if (xcnt_q == xfer_last) begin
          state_d = ACK;
          xcnt_d  = '0;
        end else begin
          xcnt_d = xcnt_q + 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Word k is addressed on XFER cycle k; its read data returns on cycle
  // k+RAM_RD_LAT, so the capture slot trails the counter by RAM_RD_LAT.
  assign issue    = (state_q == XFER) && (xcnt_q < WORDS_C);
  assign cap_en   = (state_q == XFER) && !req_q.we && (xcnt_q >= RRL_C);
  assign cap_last = cap_en && (xcnt_q == RD_LAST);
  assign cap_slot = LWA'(xcnt_q - RRL_C);

  always_comb begin
    buf_d           = buf_q;
    buf_d[cap_slot] = bus.ram_dout;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      req_q     <= '0;
      dcnt_q    <= '0;
      xcnt_q    <= '0;
      buf_q     <= '0;
      rd_line_q <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      xcnt_q  <= xcnt_d;
      if (grant) begin
        ptr_q <= ptr_d;
        gnt_q <= gnt_oh;
        req_q <= ch_req[gnt_idx];
      end
      if (cap_en) buf_q <= buf_d;
      // Published line only changes once the whole read has landed.
      if (cap_last) rd_line_q <= buf_d;
    end
  end

  assign bus.ack      = (state_q == ACK) ? gnt_q : '0;
  assign bus.busy     = (state_q != IDLE);
  assign bus.rd_line  = rd_line_q;
  assign bus.ram_addr = issue ? {req_q.addr, xcnt_q[LWA-1:0]} : '0;
  assign bus.ram_we   = issue && req_q.we;
  assign bus.ram_din  = (issue && req_q.we) ? req_q.wline[xcnt_q[LWA-1:0]] : '0;

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Directed bench for line_mem_ctrl: three instances cover the default build,
// zero access latency with a 2-cycle RAM, and a 3-channel build.
module tb_line_mem_ctrl;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  line_mem_ctrl_if #(.NCH(2)) if0();
  line_mem_ctrl_if #(.NCH(2)) if1();
  line_mem_ctrl_if #(.NCH(3)) if2();

  line_mem_ctrl #(.NCH(2)) u0 (.clk(clk), .rstn(rstn), .bus(if0.slave));
  line_mem_ctrl #(.NCH(2), .RD_LAT(0), .WR_LAT(0), .RAM_RD_LAT(2))
    u1 (.clk(clk), .rstn(rstn), .bus(if1.slave));
  line_mem_ctrl #(.NCH(3), .RD_LAT(2), .WR_LAT(2))
    u2 (.clk(clk), .rstn(rstn), .bus(if2.slave));

  // RAM models, preloaded with 0x100+i on the first edge.
  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [1024];
  logic [31:0] mem2 [1024];
  bit          ini0 = 1'b0, ini1 = 1'b0, ini2 = 1'b0;
  logic [31:0] d0, d1a, d1b, d2;

  always @(posedge clk) begin
    if (!ini0) begin
      for (int i = 0; i < 1024; i++) mem0[i] <= 32'h100 + i;
      ini0 <= 1'b1;
    end else if (if0.ram_we) mem0[if0.ram_addr] <= if0.ram_din;
    d0 <= mem0[if0.ram_addr];
  end

  always @(posedge clk) begin
    if (!ini1) begin
      for (int i = 0; i < 1024; i++) mem1[i] <= 32'h100 + i;
      ini1 <= 1'b1;
    end else if (if1.ram_we) mem1[if1.ram_addr] <= if1.ram_din;
    d1a <= mem1[if1.ram_addr];
    d1b <= d1a;
  end

  always @(posedge clk) begin
    if (!ini2) begin
      for (int i = 0; i < 1024; i++) mem2[i] <= 32'h100 + i;
      ini2 <= 1'b1;
    end else if (if2.ram_we) mem2[if2.ram_addr] <= if2.ram_din;
    d2 <= mem2[if2.ram_addr];
  end

  assign if0.ram_dout = d0;
  assign if1.ram_dout = d1b;
  assign if2.ram_dout = d2;

  // Write-strobe log for u0, sampled mid-cycle.
  int          we_n = 0;
  logic [9:0]  we_a [16];
  logic [31:0] we_d [16];
  always @(negedge clk) begin
    if (if0.ram_we) begin
      we_a[we_n % 16] <= if0.ram_addr;
      we_d[we_n % 16] <= if0.ram_din;
      we_n <= we_n + 1;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  // One u0 transaction; lat counts edges from the grant edge (inclusive)
  // to the edge after which ack is seen high.
  task automatic xact0(input int ch, input bit we, input logic [7:0] addr,
                       input logic [127:0] wl, output int lat);
    @(negedge clk);
    if0.req_we[ch]             = we;
    if0.req_addr[ch*8 +: 8]    = addr;
    if0.req_wline[ch*128 +: 128] = wl;
    if0.req_valid[ch]          = 1'b1;
    lat = 0;
    for (int cy = 0; cy < 300; cy++) begin
      @(posedge clk); #1;
      lat++;
      if (|if0.ack) break;
    end
    chk("x0_ack", 128'(if0.ack), 128'(2'b01 << ch));
    @(posedge clk); #1;
    if0.req_valid[ch] = 1'b0;
  endtask

  initial begin
    int lat, base, n, first;
    logic [1:0] alog [4];
    logic [1:0] bad;

    if0.req_valid = '0; if0.req_we = '0; if0.req_addr = '0; if0.req_wline = '0;
    if1.req_valid = '0; if1.req_we = '0; if1.req_addr = '0; if1.req_wline = '0;
    if2.req_valid = '0; if2.req_we = '0; if2.req_addr = '0; if2.req_wline = '0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 128'(if0.busy), 0);
    chk("rst_ack", 128'(if0.ack), 0);
    chk("rst_we", 128'(if0.ram_we), 0);
    chk("rst_addr", 128'(if0.ram_addr), 0);
    chk("rst_rdline", if0.rd_line, 0);
    rstn = 1'b1;

    // Both channels request together and keep requesting.
    @(negedge clk);
    if0.req_addr = {8'h02, 8'h01};
    if0.req_valid = 2'b11;
    n = 0;
    for (int cy = 0; cy < 400 && n < 4; cy++) begin
      @(posedge clk); #1;
      if (|if0.ack) begin
        alog[n] = if0.ack;
        n++;
      end
    end
    @(posedge clk); #1;
    if0.req_valid = 2'b00;
    chk("rr_n", 128'(n), 4);
    chk("rr_g0", 128'(alog[0]), 2'b01);
    chk("rr_g1", 128'(alog[1]), 2'b10);
    chk("rr_g2", 128'(alog[2]), 2'b01);
    chk("rr_g3", 128'(alog[3]), 2'b10);
    chk("rr_line", if0.rd_line, {32'h10B, 32'h10A, 32'h109, 32'h108});

    // Plain read of line 0x05.
    base = we_n;
    xact0(0, 1'b0, 8'h05, '0, lat);
    chk("rd_lat", 128'(lat), 1 + 16 + 4 + 1);
    chk("rd_line", if0.rd_line, {32'h117, 32'h116, 32'h115, 32'h114});
    chk("rd_nowe", 128'(we_n - base), 0);

    // Write line 0x3A from ch1, then read it back on ch0.
    base = we_n;
    xact0(1, 1'b1, 8'h3A, {32'hD, 32'hC, 32'hB, 32'hA}, lat);
    chk("wr_lat", 128'(lat), 1 + 16 + 4);
    chk("wr_cnt", 128'(we_n - base), 4);
    for (int k = 0; k < 4; k++) begin
      chk("wr_addr", 128'(we_a[(base + k) % 16]), 128'(10'h0E8 + k));
      chk("wr_din", 128'(we_d[(base + k) % 16]), 128'(32'hA + k));
    end
    chk("wr_keep", if0.rd_line, {32'h117, 32'h116, 32'h115, 32'h114});
    xact0(0, 1'b0, 8'h3A, '0, lat);
    chk("rb_line", if0.rd_line, {32'hD, 32'hC, 32'hB, 32'hA});

    // Reset lands after two words of a write to line 0x10.
    base = we_n;
    @(negedge clk);
    if0.req_we[1] = 1'b1;
    if0.req_addr[15:8] = 8'h10;
    if0.req_wline[255:128] = {32'h44, 32'h33, 32'h22, 32'h11};
    if0.req_valid[1] = 1'b1;
    for (int cy = 0; cy < 100 && we_n < base + 2; cy++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    rstn = 1'b0;
    if0.req_valid = 2'b00;
    repeat (2) @(negedge clk);
    chk("mr_busy", 128'(if0.busy), 0);
    chk("mr_we", 128'(if0.ram_we), 0);
    chk("mr_ack", 128'(if0.ack), 0);
    chk("mr_rdline", if0.rd_line, 0);
    rstn = 1'b1;
    chk("mr_wcnt", 128'(we_n - base), 2);
    chk("mr_w0", 128'(mem0[10'h040]), 32'h11);
    chk("mr_w1", 128'(mem0[10'h041]), 32'h22);
    chk("mr_w2", 128'(mem0[10'h042]), 32'h142);
    chk("mr_w3", 128'(mem0[10'h043]), 32'h143);
    repeat (3) @(negedge clk);
    chk("mr_noack", 128'(if0.ack), 0);
    chk("mr_idle", 128'(if0.busy), 0);
    xact0(0, 1'b0, 8'h10, '0, lat);
    chk("mr_lat", 128'(lat), 1 + 16 + 4 + 1);
    chk("mr_line", if0.rd_line, {32'h143, 32'h142, 32'h22, 32'h11});

    // Zero access latency, 2-cycle RAM.
    @(negedge clk);
    if1.req_addr[7:0] = 8'h07;
    if1.req_valid = 2'b01;
    lat = 0;
    for (int cy = 0; cy < 100; cy++) begin
      @(posedge clk); #1;
      lat++;
      if (|if1.ack) break;
    end
    chk("z_ack", 128'(if1.ack), 2'b01);
    chk("z_lat", 128'(lat), 1 + 0 + 4 + 2);
    chk("z_line", if1.rd_line, {32'h11F, 32'h11E, 32'h11D, 32'h11C});
    @(posedge clk); #1;
    if1.req_valid = 2'b00;

    // Three channels, only ch2 requesting continuously.
    @(negedge clk);
    if2.req_addr[23:16] = 8'h01;
    if2.req_valid = 3'b100;
    n = 0; lat = 0; first = 0; bad = '0;
    for (int cy = 0; cy < 400 && n < 3; cy++) begin
      @(posedge clk); #1;
      lat++;
      bad |= if2.ack[1:0];
      if (|if2.ack) begin
        if (n == 0) first = lat;
        chk("c3_ack", 128'(if2.ack), 3'b100);
        n++;
      end
    end
    @(posedge clk); #1;
    if2.req_valid = 3'b000;
    chk("c3_n", 128'(n), 3);
    chk("c3_lat", 128'(first), 1 + 2 + 4 + 1);
    chk("c3_other", 128'(bad), 0);
    chk("c3_line", if2.rd_line, {32'h107, 32'h106, 32'h105, 32'h104});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
